best_limit_scanner: RTL

Parametrised best-price scanner for the limit order book. On request it walks one side's order RAM, one entry per cycle, and returns:
- the best price (highest bid for buy, lowest ask for sell),
- the aggregate quantity resting at that price,
- the lowest index holding that price,
- the count of live orders.

It sits between the book RAMs and the matching/query FSMs and drives the RAM read ports itself.

---
 rtl/lob_pkg.sv | 26 ++
 rtl/best_limit_scanner_if.sv | 35 +++
 rtl/best_limit_accum.sv | 78 +++++++
 rtl/best_limit_scanner.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/lob_pkg.sv
// Shared limit-order-book definitions: side encoding, order word layout and the
// scanner state type.
package lob_pkg;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    // Default order word layout: {id, qty, price}, price in the low bits.
    localparam int LOB_PRICE_W = 16;
    localparam int LOB_QTY_W   = 16;
    localparam int LOB_ORDER_W = 48;
    localparam int PRICE_LSB   = 0;
    localparam int QTY_LSB     = PRICE_LSB + LOB_PRICE_W;
    localparam int ID_LSB      = QTY_LSB + LOB_QTY_W;
    localparam int ID_W        = LOB_ORDER_W - ID_LSB;

    // An all-zero word is a free slot and also terminates the packed book.
    localparam logic [LOB_ORDER_W-1:0] EMPTY_ORDER = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/best_limit_scanner_if.sv
// Request/result and book-RAM read port bundle for the best-limit scanner.
interface best_limit_scanner_if #(
    parameter int ADDR_W  = 12,
    parameter int PRICE_W = 16,
    parameter int QTY_W   = 16,
    parameter int ORDER_W = 48
);
    logic               start;
    logic               side;
    logic               abort;
    logic               buy_rd_en;
    logic               sell_rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ORDER_W-1:0] buy_rd_data;
    logic [ORDER_W-1:0] sell_rd_data;
    logic               busy;
    logic               done;
    logic               empty;
    logic [PRICE_W-1:0] best_price;
    logic [QTY_W-1:0]   best_qty;
    logic [ADDR_W-1:0]  best_idx;
    logic [ADDR_W:0]    order_cnt;

    modport slave (
        input  start, side, abort, buy_rd_data, sell_rd_data,
        output buy_rd_en, sell_rd_en, rd_addr, busy, done, empty,
               best_price, best_qty, best_idx, order_cnt
    );

    modport master (
        output start, side, abort, buy_rd_data, sell_rd_data,
        input  buy_rd_en, sell_rd_en, rd_addr, busy, done, empty,
               best_price, best_qty, best_idx, order_cnt
    );
endinterface

// File: rtl/best_limit_accum.sv
// Best-price accumulator: strict-better replace, equal-price saturating qty add,
// live order count. Ties keep the first (lowest) index seen.
module best_limit_accum
    import lob_pkg::*;
#(
    parameter int PRICE_W = 16,
    parameter int QTY_W   = 16,
    parameter int ADDR_W  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               upd_i,
    input  logic               side_i,
    input  logic [PRICE_W-1:0] price_i,
    input  logic [QTY_W-1:0]   qty_i,
    input  logic [ADDR_W-1:0]  idx_i,
    output logic [PRICE_W-1:0] best_price_o,
    output logic [QTY_W-1:0]   best_qty_o,
    output logic [ADDR_W-1:0]  best_idx_o,
    output logic [ADDR_W:0]    cnt_o
);

    logic [PRICE_W-1:0] price_q, price_d;
    logic [QTY_W-1:0]   qty_q, qty_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic               first, better, tie;
    logic [QTY_W:0]     sum;

    // First live word loads unconditionally, so the cleared register value never matters.
    assign first  = (cnt_q == '0);
    assign better = (side_i == SIDE_SELL) ? (price_i < price_q) : (price_i > price_q);
    assign tie    = (price_i == price_q);
    assign sum    = {1'b0, qty_q} + {1'b0, qty_i};

    always_comb begin
        price_d = price_q;
        qty_d   = qty_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            price_d = '0;
            qty_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (upd_i) begin
            cnt_d = cnt_q + 1'b1;
            if (first || better) begin
                price_d = price_i;
                qty_d   = qty_i;
                idx_d   = idx_i;
            end else if (tie) begin
                qty_d = sum[QTY_W] ? '1 : sum[QTY_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            price_q <= '0;
            qty_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            price_q <= price_d;
            qty_q   <= qty_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign best_price_o = price_q;
    assign best_qty_o   = qty_q;
    assign best_idx_o   = idx_q;
    assign cnt_o        = cnt_q;

endmodule

// File: rtl/best_limit_scanner.sv
// Walks one side of the order book, one entry per clock, and reports best price,
// aggregate qty at that price, its lowest index and the live order count.
module best_limit_scanner
    import lob_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int ADDR_W  = 12,
    parameter int PRICE_W = 16,
    parameter int QTY_W   = 16,
    parameter int ORDER_W = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    best_limit_scanner_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    scan_state_e        state_q, state_d;
    logic               side_q, side_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               dvld_q, dvld_d;
    logic [ADDR_W-1:0]  didx_q, didx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               empty_q, empty_d;
    logic               clr, upd;
    logic [ORDER_W-1:0] rd_word;
    logic               term;
    logic [ADDR_W:0]    cnt;

    assign rd_word = (side_q == SIDE_SELL) ? bus.sell_rd_data : bus.buy_rd_data;
    assign term    = (rd_word == ORDER_W'(EMPTY_ORDER));

    always_comb begin
        state_d   = state_q;
        side_d    = side_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        empty_d   = empty_q;
        clr       = 1'b0;
        upd       = 1'b0;
        // dvld/didx track the read issued last cycle through the RAM's one-cycle latency.
        dvld_d    = rd_en_q;
        didx_d    = rd_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_SCAN;
                    side_d    = bus.side;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
                    empty_d   = 1'b0;
                    clr       = 1'b1;
                end
            end
            ST_SCAN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    rd_en_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    if (rd_en_q) begin
                        if (rd_addr_q == LAST_IDX) rd_en_d = 1'b0;
                        else                       rd_addr_d = rd_addr_q + 1'b1;
                    end
                    if (dvld_q) begin
                        if (term) begin
                            state_d = ST_DONE;
                            rd_en_d = 1'b0;
                        end else begin
                            upd = 1'b1;
                            if (didx_q == LAST_IDX) state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                // Reads still in flight past the terminator land here and are dropped.
                state_d = ST_IDLE;
                rd_en_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                empty_d = (cnt == '0);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            side_q    <= SIDE_BUY;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            dvld_q    <= 1'b0;
            didx_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            empty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            side_q    <= side_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            dvld_q    <= dvld_d;
            didx_q    <= didx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            empty_q   <= empty_d;
        end
    end

    best_limit_accum #(
        .PRICE_W (PRICE_W),
        .QTY_W   (QTY_W),
        .ADDR_W  (ADDR_W)
    ) u_accum (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr),
        .upd_i        (upd),
        .side_i       (side_q),
        .price_i      (rd_word[PRICE_W-1:0]),
        .qty_i        (rd_word[PRICE_W +: QTY_W]),
        .idx_i        (didx_q),
        .best_price_o (bus.best_price),
        .best_qty_o   (bus.best_qty),
        .best_idx_o   (bus.best_idx),
        .cnt_o        (cnt)
    );

    assign bus.order_cnt  = cnt;
    assign bus.buy_rd_en  = rd_en_q & (side_q == SIDE_BUY);
    assign bus.sell_rd_en = rd_en_q & (side_q == SIDE_SELL);
    assign bus.rd_addr    = rd_addr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.empty      = empty_q;

endmodule
